// File: rtl/tate_pairing_sched_pkg.sv
// Shared constants, FSM state type and operand pack/unpack helpers for the
// pairing-core job scheduler.
package tate_pairing_sched_pkg;

    localparam int unsigned OPW    = 194;  // 97 trits x 2 bits
    localparam int unsigned OUTW   = 150;
    localparam int unsigned NWORDS = 8;
    localparam int unsigned LASTW  = 114;

    localparam logic [2:0]      LAST_IDX  = 3'(NWORDS - 1);
    localparam logic [OUTW-1:0] LAST_MASK = {{(OUTW - LASTW){1'b0}}, {LASTW{1'b1}}};

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRun,
        StSel,
        StCap,
        StHold
    } sched_state_t;

    // Field order matches the request bus packing: x1 in the MSBs
    typedef struct packed {
        logic [OPW-1:0] x1;
        logic [OPW-1:0] y1;
        logic [OPW-1:0] x2;
        logic [OPW-1:0] y2;
    } opnd_t;

    function automatic opnd_t opnd_unpack(input logic [4*OPW-1:0] v);
        return opnd_t'(v);
    endfunction

    function automatic logic [4*OPW-1:0] opnd_pack(input logic [OPW-1:0] x1,
                                                   input logic [OPW-1:0] y1,
                                                   input logic [OPW-1:0] x2,
                                                   input logic [OPW-1:0] y2);
        return {x1, y1, x2, y2};
    endfunction

endpackage

// File: rtl/tate_pairing_sched_if.sv
// Request and result handshake bundle between the requesters/consumer and
// the scheduler.
interface tate_pairing_sched_if;
    import tate_pairing_sched_pkg::*;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [4*OPW-1:0] req0_opnd;
    logic [4*OPW-1:0] req1_opnd;
    logic             res_valid;
    logic             res_ready;
    logic [OUTW-1:0]  res_data;
    logic [2:0]       res_idx;
    logic             res_id;
    logic             res_last;

    modport master (
        output req_valid, req0_opnd, req1_opnd, res_ready,
        input  req_ready, res_valid, res_data, res_idx, res_id, res_last
    );

    modport slave (
        input  req_valid, req0_opnd, req1_opnd, res_ready,
        output req_ready, res_valid, res_data, res_idx, res_id, res_last
    );

endinterface

// File: rtl/tate_pairing_sched_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer toggles on each advance.
module tate_pairing_sched_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_ptr;

    // Priority pointer: flips once per accepted job
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~r_ptr;
        end
    end

    // Pointer holder wins; otherwise the other requester if it is pending
    always_comb begin
        o_grant = 2'b00;
        if (!r_ptr) begin
            if (i_req[0])      o_grant = 2'b01;
            else if (i_req[1]) o_grant = 2'b10;
        end else begin
            if (i_req[1])      o_grant = 2'b10;
            else if (i_req[0]) o_grant = 2'b01;
        end
    end

endmodule

// File: rtl/tate_pairing_sched.sv
// Shares one pairing core between two requesters: arbitrates, latches
// operands, pulses the core start, then walks the readout mux and streams the
// eight result words out. A watchdog aborts jobs that never finish.
module tate_pairing_sched
    import tate_pairing_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = 2**20
) (
    input  logic            i_clk,
    input  logic            i_reset,
    tate_pairing_sched_if.slave bus,
    output logic            o_core_start,
    output logic [OPW-1:0]  o_core_x1,
    output logic [OPW-1:0]  o_core_y1,
    output logic [OPW-1:0]  o_core_x2,
    output logic [OPW-1:0]  o_core_y2,
    input  logic            i_core_done,
    output logic [2:0]      o_core_sel,
    input  logic [OUTW-1:0] i_core_out,
    output logic            o_busy,
    output logic            o_timeout_err
);

    localparam int unsigned WDW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

    sched_state_t r_state, w_state_next;

    logic [1:0]      w_grant, w_req_ready;
    logic            w_accept, w_done_edge, w_timeout, w_res_hs;
    opnd_t           w_opnd;

    logic            r_done_prev;
    logic [WDW-1:0]  r_wd;
    logic [2:0]      r_k;
    logic [OPW-1:0]  r_x1, r_y1, r_x2, r_y2;
    logic            r_res_valid, r_res_id, r_res_last, r_timeout_err;
    logic [OUTW-1:0] r_res_data;
    logic [2:0]      r_res_idx;

    tate_pairing_sched_rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (bus.req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    // Ready is forced low during reset so every output reads 0 while it is held
    assign w_req_ready = (r_state == StIdle && !i_reset) ? w_grant : 2'b00;
    assign w_accept    = |(bus.req_valid & w_req_ready);
    assign w_opnd      = opnd_unpack(w_grant[1] ? bus.req1_opnd : bus.req0_opnd);
    // r_done_prev is forced high in START, so a stale or first-cycle done never counts
    assign w_done_edge = (r_state == StRun) && !r_done_prev && i_core_done;
    assign w_timeout   = (r_state == StRun) && (r_wd == WD_MAX);
    assign w_res_hs    = (r_state == StHold) && r_res_valid && bus.res_ready;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    // Next-state decode; a completion on the last watchdog cycle still wins
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StStart;
            StStart: w_state_next = StRun;
            StRun: begin
                if (w_done_edge)    w_state_next = StSel;
                else if (w_timeout) w_state_next = StIdle;
            end
            StSel:   w_state_next = StCap;
            StCap:   w_state_next = StHold;
            StHold:  if (w_res_hs) w_state_next = (r_k == LAST_IDX) ? StIdle : StSel;
            default: w_state_next = StIdle;
        endcase
    end

    // Done edge history, watchdog, word index and sticky abort flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_done_prev   <= 1'b0;
            r_wd          <= '0;
            r_k           <= 3'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done_prev <= (r_state == StStart) ? 1'b1 : i_core_done;
            if (r_state == StStart)                   r_wd <= '0;
            else if (r_state == StRun && r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
            if (w_done_edge)                          r_k <= 3'd0;
            else if (w_res_hs && r_k != LAST_IDX)     r_k <= r_k + 3'd1;
            if (w_accept)                             r_timeout_err <= 1'b0;
            else if (w_timeout && !w_done_edge)       r_timeout_err <= 1'b1;
        end
    end

    // Operand and owner latch on request accept
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_x1     <= '0;
            r_y1     <= '0;
            r_x2     <= '0;
            r_y2     <= '0;
            r_res_id <= 1'b0;
        end else if (w_accept) begin
            r_x1     <= w_opnd.x1;
            r_y1     <= w_opnd.y1;
            r_x2     <= w_opnd.x2;
            r_y2     <= w_opnd.y2;
            r_res_id <= w_grant[1];
        end
    end

    // Result word capture in CAP, release on the HOLD handshake
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_res_data  <= '0;
            r_res_idx   <= 3'd0;
        end else if (r_state == StCap) begin
            r_res_valid <= 1'b1;
            r_res_last  <= (r_k == LAST_IDX);
            r_res_data  <= (r_k == LAST_IDX) ? (i_core_out & LAST_MASK) : i_core_out;
            r_res_idx   <= r_k;
        end else if (w_res_hs) begin
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_idx   = r_res_idx;
    assign bus.res_id    = r_res_id;
    assign bus.res_last  = r_res_last;

    assign o_core_start  = (r_state == StStart);
    assign o_core_x1     = r_x1;
    assign o_core_y1     = r_y1;
    assign o_core_x2     = r_x2;
    assign o_core_y2     = r_y2;
    assign o_core_sel    = r_k;
    assign o_busy        = (r_state != StIdle);
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_tate_pairing_sched.sv
// Directed bench for the pairing-core scheduler with a behavioural core stand-in.
module tb_tate_pairing_sched;
    import tate_pairing_sched_pkg::*;

    localparam int unsigned TO = 64;
    localparam logic [OPW-1:0] SEED0 = 194'h6a18950064046a122a14118668466a262a91509688159890;
    localparam logic [OPW-1:0] SEED1 = 194'h1f2e3d4c5b6a798897a6b5c4d3e2f1000112233445566778;

    logic            clk = 1'b0;
    logic            rst;
    logic            core_start;
    logic [OPW-1:0]  core_x1, core_y1, core_x2, core_y2;
    logic            core_done;
    logic [2:0]      core_sel;
    logic [OUTW-1:0] core_out;
    logic            busy, terr;
    logic [OPW-1:0]  model_x1;

    int total = 0;
    int bad   = 0;
    int job_no = 0;

    typedef struct {
        logic [1:0] valid;
        logic       exp_id;
        int         stall_k;
    } vec_t;

    tate_pairing_sched_if bus ();

    tate_pairing_sched #(.TIMEOUT(TO)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .bus           (bus),
        .o_core_start  (core_start),
        .o_core_x1     (core_x1),
        .o_core_y1     (core_y1),
        .o_core_x2     (core_x2),
        .o_core_y2     (core_y2),
        .i_core_done   (core_done),
        .o_core_sel    (core_sel),
        .i_core_out    (core_out),
        .o_busy        (busy),
        .o_timeout_err (terr)
    );

    always #5 clk = ~clk;

    // Core stand-in: readout word is a fixed function of the job's x1 and sel
    function automatic logic [OUTW-1:0] core_word(input logic [OPW-1:0] x1, input logic [2:0] s);
        logic [OUTW-1:0] v;
        v = x1[OUTW-1:0] ^ ({OUTW{1'b1}} >> (int'(s) * 13));
        v[OUTW-1 -: 3] = v[OUTW-1 -: 3] ^ s;
        return v;
    endfunction

    assign core_out = core_word(model_x1, core_sel);

    function automatic logic [4*OPW-1:0] mk_opnd(input logic id, input int job);
        logic [OPW-1:0] b;
        b = id ? SEED1 : SEED0;
        b = b ^ (OPW'(job) << 120) ^ OPW'(job);
        return opnd_pack(b, {b[96:0], b[193:97]}, ~b, b ^ {97{2'b01}});
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input logic [1:0] valid, input logic exp_id, input int stall_k,
                           input bit stale, input int abort_k, input string tag);
        logic [4*OPW-1:0] v0, v1, ve;
        logic [OUTW-1:0]  ew, mask;
        int n;
        mask = '0;
        for (int i = 0; i < 114; i++) mask[i] = 1'b1;
        job_no++;
        v0 = mk_opnd(1'b0, job_no);
        v1 = mk_opnd(1'b1, job_no);
        ve = exp_id ? v1 : v0;
        @(negedge clk);
        bus.req0_opnd = v0;
        bus.req1_opnd = v1;
        bus.req_valid = valid;
        model_x1 = ve[4*OPW-1 -: OPW];
        #1;
        chk({tag, " req_ready"}, 256'(bus.req_ready), exp_id ? 256'd2 : 256'd1);
        chk({tag, " idle_busy"}, 256'(busy), 256'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        if (!stale) core_done = 1'b0;
        chk({tag, " start"}, 256'(core_start), 256'd1);
        chk({tag, " busy"}, 256'(busy), 256'd1);
        chk({tag, " terr_clr"}, 256'(terr), 256'd0);
        chk({tag, " x1"}, 256'(core_x1), 256'(ve[4*OPW-1 -: OPW]));
        chk({tag, " y1"}, 256'(core_y1), 256'(ve[3*OPW-1 -: OPW]));
        chk({tag, " x2"}, 256'(core_x2), 256'(ve[2*OPW-1 -: OPW]));
        chk({tag, " y2"}, 256'(core_y2), 256'(ve[OPW-1:0]));
        @(posedge clk);
        #1;
        chk({tag, " start_pulse"}, 256'(core_start), 256'd0);
        if (stale) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                chk({tag, " stale_quiet"}, 256'(bus.res_valid), 256'd0);
            end
            core_done = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end else begin
            repeat (4) @(posedge clk);
            #1;
        end
        core_done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!bus.res_valid && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk({tag, " word_lat"}, 256'(n), (k == 0) ? 256'd3 : 256'd2);
            ew = core_word(model_x1, 3'(k));
            if (k == 7) ew = ew & mask;
            chk({tag, " data"}, 256'(bus.res_data), 256'(ew));
            chk({tag, " idx"}, 256'(bus.res_idx), 256'(k));
            chk({tag, " last"}, 256'(bus.res_last), (k == 7) ? 256'd1 : 256'd0);
            chk({tag, " id"}, 256'(bus.res_id), 256'(exp_id));
            chk({tag, " sel"}, 256'(core_sel), 256'(k));
            if (k == stall_k) begin
                bus.res_ready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk);
                    #1;
                    chk({tag, " stall_valid"}, 256'(bus.res_valid), 256'd1);
                    chk({tag, " stall_data"}, 256'(bus.res_data), 256'(ew));
                    chk({tag, " stall_idx"}, 256'(bus.res_idx), 256'(k));
                    chk({tag, " stall_sel"}, 256'(core_sel), 256'(k));
                end
                bus.res_ready = 1'b1;
            end
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                chk({tag, " rst_start"}, 256'(core_start), 256'd0);
                chk({tag, " rst_busy"}, 256'(busy), 256'd0);
                chk({tag, " rst_valid"}, 256'(bus.res_valid), 256'd0);
                chk({tag, " rst_last"}, 256'(bus.res_last), 256'd0);
                chk({tag, " rst_idx"}, 256'(bus.res_idx), 256'd0);
                chk({tag, " rst_data"}, 256'(bus.res_data), 256'd0);
                chk({tag, " rst_sel"}, 256'(core_sel), 256'd0);
                chk({tag, " rst_x1"}, 256'(core_x1), 256'd0);
                chk({tag, " rst_id"}, 256'(bus.res_id), 256'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            chk({tag, " valid_drop"}, 256'(bus.res_valid), 256'd0);
        end
        chk({tag, " end_idle"}, 256'(busy), 256'd0);
        chk({tag, " end_terr"}, 256'(terr), 256'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL tb_watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        bit   seen;
        tbl[0] = '{2'b11, 1'b0, -1};  // contention: pointer 0 holder wins
        tbl[1] = '{2'b11, 1'b1, -1};  // loser served next
        tbl[2] = '{2'b11, 1'b0, -1};  // pointer toggled twice
        tbl[3] = '{2'b01, 1'b0, -1};
        tbl[4] = '{2'b10, 1'b1, -1};
        tbl[5] = '{2'b11, 1'b1, 3};   // backpressure on word 3

        rst           = 1'b1;
        core_done     = 1'b0;
        model_x1      = '0;
        bus.req_valid = 2'b11;
        bus.req0_opnd = '0;
        bus.req1_opnd = '0;
        bus.res_ready = 1'b1;
        #1;
        chk("reset req_ready", 256'(bus.req_ready), 256'd0);
        chk("reset start", 256'(core_start), 256'd0);
        chk("reset busy", 256'(busy), 256'd0);
        chk("reset res_valid", 256'(bus.res_valid), 256'd0);
        chk("reset terr", 256'(terr), 256'd0);
        chk("reset sel", 256'(core_sel), 256'd0);
        chk("reset x1", 256'(core_x1), 256'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst = 1'b0;

        for (int r = 0; r < 6; r++) begin
            run_job(tbl[r].valid, tbl[r].exp_id, tbl[r].stall_k, 1'b0, -1, $sformatf("tbl%0d", r));
        end

        // Watchdog abort with done stuck low
        job_no++;
        @(negedge clk);
        bus.req0_opnd = mk_opnd(1'b0, job_no);
        bus.req1_opnd = mk_opnd(1'b1, job_no);
        bus.req_valid = 2'b01;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        core_done = 1'b0;
        chk("to start", 256'(core_start), 256'd1);
        @(posedge clk);
        #1;
        seen = 1'b0;
        for (int i = 0; i < 63; i++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) seen = 1'b1;
        end
        chk("to early terr", 256'(terr), 256'd0);
        chk("to early busy", 256'(busy), 256'd1);
        @(posedge clk);
        #1;
        chk("to terr", 256'(terr), 256'd1);
        chk("to idle", 256'(busy), 256'd0);
        chk("to no result", 256'(seen), 256'd0);

        // Stale done high into START/RUN; abort also toggled the pointer
        core_done = 1'b1;
        run_job(2'b11, 1'b1, -1, 1'b1, -1, "stale");

        // Reset during HOLD of word 5, then a fresh req1 job
        run_job(2'b01, 1'b0, -1, 1'b0, 5, "abort");
        run_job(2'b10, 1'b1, -1, 1'b0, -1, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tate_pairing_sched.md
# tate_pairing_sched

Job scheduler that shares one `tate_pairing` core between two requesters. It arbitrates round-robin, latches the winner's operands, and starts the core with a one-cycle pulse on the core's `reset`. When the core reports `done`, it walks the 3-bit `sel` readout mux through all 8 result words and streams them out over a valid/ready interface, tagged with the requester ID. A watchdog aborts jobs that never complete.

## Interface
- `OPW`, 194: operand width in bits (97 trits × 2 bits).
- `OUTW`, 150: readout word width.
- `NWORDS`, 8: readout words per result.
- `LASTW`, 114: valid low bits in word 7; bits above are forced to 0.
- `TIMEOUT`, 2^20: maximum cycles in RUN before abort.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  2  request pending, one bit per requester.
- `req_ready`  out  2  one-hot accept.
- `req0_opnd`, `req1_opnd`  in  4*OPW  packed as {x1,y1,x2,y2}, x1 in the MSBs.
- `core_start`  out  1  drives the core's `reset`.
- `core_x1`, `core_y1`, `core_x2`, `core_y2`  out  OPW  registered operands.
- `core_done`  in  1  core completion level.
- `core_sel`  out  3  readout word select.
- `core_out`  in  OUTW  readout word.
- `res_valid`  out  1  result word valid.
- `res_ready`  in  1  downstream accept.
- `res_data`  out  OUTW  result word.
- `res_idx`  out  3  word index, 0..7.
- `res_id`  out  1  requester that owns the result.
- `res_last`  out  1  high with word 7.
- `busy`  out  1  state is not IDLE.
- `timeout_err`  out  1  sticky abort flag; cleared on the next accept.

## Operation
- States: IDLE → START → RUN → SEL → CAP → HOLD → (SEL or IDLE).
- **IDLE**
  - Round-robin between requesters that have `req_valid` high.
  - Priority pointer resets to 0 and toggles after each accepted job, including aborted jobs.
  - `req_ready[g]` is high combinationally while the state is IDLE and g is the grantee.
  - A handshake (`req_valid[g]` & `req_ready[g]`) latches the operands into `core_*`, sets `res_id`=g, clears `timeout_err`, and moves to START.
- **START**
  - `core_start`=1 for exactly one cycle, then RUN.
  - Operands stay stable from START until the next accept.
- **RUN**
  - Watchdog counter counts from 0.
  - The first cycle in RUN ignores `core_done` (a stale high from the previous job is not a completion).
  - Completion requires `core_done` sampled 0 then 1, via a registered edge detector armed at START.
  - On completion: word index k=0, go to SEL.
  - If the counter reaches TIMEOUT-1: set `timeout_err`, emit no result, go to IDLE.
- **SEL**: drive `core_sel`=k for one settling cycle, then CAP.
- **CAP**
  - Register `core_out` into `res_data`. When k=7, bits OUTW-1..LASTW are zeroed.
  - Set `res_idx`=k, `res_last`=(k==7), `res_valid`=1, go to HOLD.
- **HOLD**
  - Hold `res_*` stable until `res_ready`.
  - On handshake: `res_valid`=0. If k<7: k+1, go to SEL. If k=7: go to IDLE.
- Arithmetic:
  - k is 3 bits; it never wraps because the k=7 exit is checked first.
  - Watchdog is ceil(log2(TIMEOUT)) bits and saturates.

## Timing
- Reset values:
  - state IDLE; `core_start`, `core_sel`, `res_*`, `busy`, `timeout_err`, `req_ready` all 0.
  - `core_x*` 0; priority pointer 0.
- Request handshake to `core_start` high: 1 cycle.
- `core_done` rising edge to the first `res_valid`: 3 cycles (edge register, SEL, CAP).
- Each word takes at least 3 cycles (SEL, CAP, HOLD). With `res_ready` held high, 8 words take 24 cycles.
- `core_sel` changes only on SEL entry and is stable for ≥2 cycles before capture.
- Both requesters valid on the same cycle: the priority holder wins. The loser keeps `req_valid` high and is served on the next IDLE.
- A requester dropping `req_valid` while not granted has no effect.
- `reset` asserted mid-job (any state):
  - Immediate return to IDLE; `core_start` goes low asynchronously.
  - The partial result is discarded, with no `res_last`.
  - The core must be re-run by a new request.
- `res_ready` high while `res_valid` is low is ignored.

## Structure
- Shared package `pairing_pkg`: OPW/OUTW/NWORDS/LASTW constants, `sched_state_t` enum, operand pack/unpack helpers.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with a registered pointer and an `advance` input.
- The FSM, operand registers, watchdog and result registers live in the top module.
- The `tate_pairing` core is instantiated outside, at the next level up.

## Test plan
- **Single job.** req0 with x1=194'h6a18950064046a122a14118668466a262a91509688159890, plus the matching y1/x2/y2 vectors, against the real core.
  - Required: 8 words with idx 0..7, `res_last` only on word 7, `res_id`=0.
  - Concatenated words equal the 1164-bit golden result.
- **Contention.** Both requests valid on the same cycle.
  - Required: req0 served first, then req1.
  - A third job with both valid again goes to req0 (pointer toggled twice).
- **Backpressure.** `res_ready` held low for 10 cycles on word 3.
  - Required: `res_data`/`res_idx` stable throughout, `core_sel`=3 held, no word skipped or duplicated.
- **Timeout.** TIMEOUT=64, `core_done` stuck 0.
  - Required: `timeout_err` rises 64 cycles after RUN entry, no `res_valid`, back to IDLE.
  - The next accept clears the flag.
- **Stale done.** `core_done` held 1 from the previous job into START/RUN.
  - Required: no readout until `core_done` falls and rises again.
- **Reset mid-job.** `reset` during HOLD of word 5.
  - Required: all outputs 0 immediately, IDLE.
  - A fresh req1 job completes with all 8 words correct.
